// File: rtl/mult64_arbiter.sv
// mult64_arbiter: round-robin sharing of one pipelined 64x64 multiplier; per-requester req/rsp valid-ready, registered mul_a/mul_b out, mul_result in, idle and op_count status
module mult64_arbiter #(
  parameter int NREQ = 4,
  parameter int MUL_LAT = 3,
  parameter int IDW = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*64-1:0]  req_a,
  input  logic [NREQ*64-1:0]  req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [NREQ*128-1:0] rsp_data,
  output logic [63:0]         mul_a,
  output logic [63:0]         mul_b,
  input  logic [127:0]        mul_result,
  output logic                idle,
  output logic [31:0]         op_count
);
  logic [IDW-1:0] ptr_q, ptr_d, gid, j, fid;
  logic [NREQ-1:0] inflight_q, inflight_d, rsp_valid_q, rsp_valid_d, elig, grant, rsp_set;
  logic [NREQ-1:0][127:0] rsp_data_q, rsp_data_d;
  logic [NREQ-1:0][63:0] a_v, b_v;
  logic [63:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [31:0] op_count_q, op_count_d;
  logic [MUL_LAT:0] tag_v_q, tag_v_d;
  logic [MUL_LAT:0][IDW-1:0] tag_id_q, tag_id_d;
  logic acc, fin;
  assign a_v = req_a;
  assign b_v = req_b;
  assign elig = req_valid & ~(inflight_q | rsp_valid_q);
  assign fin = tag_v_q[MUL_LAT];
  assign fid = tag_id_q[MUL_LAT];
  assign rsp_set = fin ? NREQ'(1) << fid : '0;
  assign acc = |grant;
  always_comb begin
    grant = '0;
    gid = '0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr_q) + k) % NREQ);
      if (elig[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        gid = j;
      end
    end
  end
  always_comb begin
    ptr_d = acc ? IDW'((int'(gid) + 1) % NREQ) : ptr_q;
    mul_a_d = acc ? a_v[gid] : mul_a_q;
    mul_b_d = acc ? b_v[gid] : mul_b_q;
    op_count_d = op_count_q + {31'd0, acc};
    tag_v_d = {tag_v_q[MUL_LAT-1:0], acc};
    tag_id_d = {tag_id_q[MUL_LAT-1:0], gid};
    inflight_d = (inflight_q | grant) & ~rsp_set;
    rsp_valid_d = (rsp_valid_q & ~rsp_ready) | rsp_set;
    rsp_data_d = rsp_data_q;
    if (fin) rsp_data_d[fid] = mul_result;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
      inflight_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      op_count_q <= '0;
      tag_v_q <= '0;
      tag_id_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      inflight_q <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      op_count_q <= op_count_d;
      tag_v_q <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end
  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign op_count = op_count_q;
  assign idle = ~|(inflight_q | rsp_valid_q);
endmodule

// File: tb/tb_mult64_arbiter.sv
// tb_mult64_arbiter: directed self-checking bench for mult64_arbiter with a behavioural 3-stage multiplier
module tb_mult64_arbiter;
  localparam int NREQ = 4;
  localparam int MUL_LAT = 3;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] rsp_ready = '0;
  logic [NREQ*64-1:0] req_a = '0;
  logic [NREQ*64-1:0] req_b = '0;
  logic [NREQ-1:0] req_ready, rsp_valid;
  logic [NREQ*128-1:0] rsp_data;
  logic [63:0] mul_a, mul_b;
  logic [127:0] mul_result;
  logic idle;
  logic [31:0] op_count;
  logic [127:0] pipe [MUL_LAT];
  int total = 0;
  int bad = 0;
  mult64_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .idle(idle), .op_count(op_count)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    pipe[0] <= {64'd0, mul_a} * {64'd0, mul_b};
    for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mul_result = pipe[MUL_LAT-1];
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic put(input int i, input logic [63:0] a, input logic [63:0] b);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
  endtask
  function automatic logic [127:0] rd(input int i);
    return rsp_data[i*128 +: 128];
  endfunction
  initial begin
    tick(2);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data[127:0] | rsp_data[255:128] | rsp_data[383:256] | rsp_data[511:384], 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_idle", idle, 1);
    reset = 1'b1;
    tick(1);
    for (int i = 0; i < NREQ; i++) put(i, 64'(i + 1), 64'd10);
    req_valid = '1;
    for (int t = 0; t < 9; t++) begin
      #1;
      chk($sformatf("all_rr%0d", t), req_ready, t < 4 ? 1 << t : 0);
      chk($sformatf("all_rv%0d", t), rsp_valid, t < 5 ? 0 : (1 << (t - 4)) - 1);
      tick(1);
    end
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) chk($sformatf("all_data%0d", i), rd(i), 128'(10 * (i + 1)));
    chk("all_op_count", op_count, 4);
    rsp_ready = '1;
    tick(1);
    rsp_ready = '0;
    #1;
    chk("all_drained", rsp_valid, 0);
    chk("all_idle", idle, 1);
    put(2, 64'd3, 64'd5);
    req_valid = 4'b0100;
    #1;
    chk("b2b_first_grant", req_ready, 4'b0100);
    tick(1);
    for (int t = 1; t < 9; t++) begin
      #1;
      chk($sformatf("b2b_block%0d", t), req_ready, 0);
      if (t >= 5) begin
        chk($sformatf("b2b_rv%0d", t), rsp_valid, 4'b0100);
        chk($sformatf("b2b_hold%0d", t), rd(2), 15);
      end
      if (t == 8) rsp_ready = 4'b0100;
      tick(1);
    end
    rsp_ready = '0;
    put(2, 64'd4, 64'd5);
    #1;
    chk("b2b_second_grant", req_ready, 4'b0100);
    chk("b2b_cleared", rsp_valid, 0);
    tick(1);
    req_valid = '0;
    tick(3);
    #1;
    chk("b2b_old_data", rd(2), 15);
    chk("b2b_not_yet", rsp_valid, 0);
    tick(1);
    #1;
    chk("b2b_rv2", rsp_valid, 4'b0100);
    chk("b2b_new_data", rd(2), 20);
    rsp_ready = 4'b0100;
    tick(1);
    rsp_ready = '0;
    put(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    req_valid = 4'b0010;
    #1;
    chk("one_ready", req_ready, 4'b0010);
    tick(1);
    req_valid = '0;
    #1;
    chk("one_mul_a", mul_a, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("one_mul_b", mul_b, 2);
    chk("one_busy", idle, 0);
    tick(3);
    #1;
    chk("one_early", rsp_valid, 0);
    tick(1);
    #1;
    chk("one_rv", rsp_valid, 4'b0010);
    chk("one_data", rd(1), 128'h1_FFFF_FFFF_FFFF_FFFE);
    chk("one_idle_hold", idle, 0);
    rsp_ready = 4'b0010;
    tick(1);
    rsp_ready = '0;
    #1;
    chk("one_drained", rsp_valid, 0);
    chk("one_idle", idle, 1);
    chk("one_op_count", op_count, 7);
    put(0, 64'd5, 64'd6);
    put(3, 64'd7, 64'd8);
    req_valid = 4'b1001;
    #1;
    chk("fair_first", req_ready, 4'b1000);
    tick(1);
    #1;
    chk("fair_second", req_ready, 4'b0001);
    tick(1);
    req_valid = '0;
    tick(3);
    #1;
    chk("fair_rv3", rsp_valid, 4'b1000);
    tick(1);
    #1;
    chk("fair_rv_both", rsp_valid, 4'b1001);
    chk("fair_data0", rd(0), 30);
    chk("fair_data3", rd(3), 56);
    rsp_ready = 4'b1001;
    tick(1);
    rsp_ready = '0;
    put(0, 64'd7, 64'd6);
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    tick(1);
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    #1;
    chk("mid_op_count", op_count, 0);
    chk("mid_idle", idle, 1);
    chk("mid_mul_a", mul_a, 0);
    for (int t = 0; t < 10; t++) begin
      chk($sformatf("mid_no_rsp%0d", t), rsp_valid, 0);
      tick(1);
      #1;
    end
    force dut.op_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.op_count_q;
    chk("wrap_preload", op_count, 32'hFFFF_FFFF);
    put(2, 64'd9, 64'd9);
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    #1;
    chk("wrap_zero", op_count, 0);
    tick(4);
    #1;
    chk("wrap_rv", rsp_valid, 4'b0100);
    chk("wrap_data", rd(2), 81);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
